// File: rtl/intcode_mem_arbiter.sv
// intcode_mem_arbiter: shares one single-port 32-bit RAM between m0 (CPU) and m1 (loader/debug), round-robin.
// Latency: req sampled in IDLE -> ack 3 cycles later (write/error) or 3+READ_LATENCY (read).
// Backpressure: masters hold req until ack; the losing master simply waits in IDLE arbitration.
// Ports: clock, reset (async active-low); m0_*/m1_* request/we/addr/wdata in, ack/err/rdata out
//   (ack/err one-cycle pulse, rdata valid only with ack); mem_* RAM address/strobes/data.
// Optional: `define ARB_LOCK_EN adds m0_lock/m1_lock so a master can keep the RAM across transactions.
module intcode_mem_arbiter #(
  parameter int unsigned RAM_WORDS    = 2048,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] mem_address,
  output logic        mem_we,
  output logic        mem_oe,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef ARB_LOCK_EN
  ,
  input  logic        m0_lock,
  input  logic        m1_lock
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, ACK} state_t;

  state_t      state;
  logic        last_grant;
  logic        cur_grant;
  logic        lat_we;
  logic        lat_err;
  logic [2:0]  wait_cnt;
  logic [31:0] rd_buf;

  logic        ack_out;
  logic        gnt_vld;
  logic        gnt_id;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_ok;

`ifdef ARB_LOCK_EN
  logic        reserved;
  logic        res_id;
`endif

  // The ack pulse is registered out of the ACK state, so it lands in a cycle
  // where the FSM is already back in IDLE. That cycle never grants: a master
  // may still be holding req while it sees its own ack.
  assign ack_out   = m0_ack | m1_ack;
  assign sel_we    = gnt_id ? m1_we    : m0_we;
  assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;
  assign addr_ok   = sel_addr < RAM_WORDS;

  always_comb begin
    gnt_vld = m0_req | m1_req;
    gnt_id  = 1'b0;
    if (m0_req && m1_req) gnt_id = ~last_grant;
    else if (m1_req)      gnt_id = 1'b1;
`ifdef ARB_LOCK_EN
    // A reserved master is the only candidate; the other one waits.
    if (reserved) begin
      gnt_id  = res_id;
      gnt_vld = res_id ? m1_req : m0_req;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_grant   <= 1'b0;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      wait_cnt    <= '0;
      rd_buf      <= '0;
      m0_rdata    <= '0;
      m0_ack      <= 1'b0;
      m0_err      <= 1'b0;
      m1_rdata    <= '0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      mem_address <= '0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_wdata   <= '0;
`ifdef ARB_LOCK_EN
      reserved    <= 1'b0;
      res_id      <= 1'b0;
`endif
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      case (state)
        IDLE: begin
`ifdef ARB_LOCK_EN
          // Lock is sampled in the ack cycle of the granted master.
          if (ack_out) begin
            reserved <= cur_grant ? m1_lock : m0_lock;
            res_id   <= cur_grant;
          end
`endif
          if (gnt_vld && !ack_out) begin
            cur_grant  <= gnt_id;
            last_grant <= gnt_id;
            lat_we     <= sel_we;
            lat_err    <= ~addr_ok;
            state      <= ACCESS;
            // RAM strobes are launched on the grant edge so they are
            // visible exactly during the ACCESS cycle; bad addresses never reach the RAM.
            if (addr_ok) begin
              mem_address <= sel_addr;
              mem_we      <= sel_we;
              mem_oe      <= ~sel_we;
              mem_wdata   <= sel_we ? sel_wdata : 32'd0;
            end
          end
        end
        ACCESS: begin
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          if (!lat_err && !lat_we) begin
            wait_cnt <= 3'(READ_LATENCY);
            state    <= RWAIT;
          end else begin
            mem_address <= '0;
            state       <= ACK;
          end
        end
        RWAIT: begin
          if (wait_cnt == 3'd1) begin
            rd_buf      <= mem_rdata;
            mem_oe      <= 1'b0;
            mem_address <= '0;
            state       <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          state <= IDLE;
          if (cur_grant) begin
            m1_ack   <= 1'b1;
            m1_err   <= lat_err;
            m1_rdata <= (!lat_err && !lat_we) ? rd_buf : 32'd0;
          end else begin
            m0_ack   <= 1'b1;
            m0_err   <= lat_err;
            m0_rdata <= (!lat_err && !lat_we) ? rd_buf : 32'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intcode_mem_arbiter.sv
module tb_intcode_mem_arbiter;
  localparam int unsigned WORDS = 2048;
  localparam int unsigned RL    = 1;

  logic        clock;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_we, mem_oe;
`ifdef ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int overlap_cnt = 0;

  bit [31:0] ram     [0:WORDS-1];  // the RAM the DUT talks to
  bit [31:0] ref_ram [0:WORDS-1];  // expected contents, updated only by the model
  bit        ref_lg;                // model: last granted master

  intcode_mem_arbiter #(.RAM_WORDS(WORDS), .READ_LATENCY(RL)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_address(mem_address), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef ARB_LOCK_EN
    , .m0_lock(m0_lock), .m1_lock(m1_lock)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM, one cycle from mem_oe to data.
  always @(posedge clock) begin
    if (mem_we) ram[mem_address[10:0]] <= mem_wdata;
    if (mem_oe) mem_rdata <= ram[mem_address[10:0]];
  end

  always @(negedge clock) if (mem_we && mem_oe) overlap_cnt <= overlap_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 32'hFFFF0000;
    if (k == 1) return $urandom | 32'h0000_0800;
    if (k == 2) return 32'd2047;
    return 32'($urandom_range(0, 15));
  endfunction

  // One arbitration round: raise the chosen reqs together (FSM idle), then
  // expect acks in round-robin order with spec latencies, each master
  // dropping req in its ack cycle.
  task automatic run_round(input bit r0, input bit r1, input bit we0, input bit we1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
    int order[$];
    int cyc, k, m, exp_t, we_cnt, oe_cnt;
    bit we, bad;
    logic [31:0] addr, wd, we_addr, we_dat, exp_rd;
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    if (r0 && r1) begin
      order.push_back(ref_lg ? 0 : 1);
      order.push_back(ref_lg ? 1 : 0);
    end else if (r0) order.push_back(0);
    else if (r1) order.push_back(1);
    cyc = 0; k = 0; exp_t = 0; we_cnt = 0; oe_cnt = 0;
    we_addr = '0; we_dat = '0;
    while (k < order.size() && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (mem_we) begin we_cnt++; we_addr = mem_address; we_dat = mem_wdata; end
      if (mem_oe) oe_cnt++;
      if (m0_ack || m1_ack) begin
        m    = order[k];
        we   = m ? we1 : we0;
        addr = m ? a1 : a0;
        wd   = m ? d1 : d0;
        bad  = addr >= WORDS;
        exp_t += (bad || we) ? 3 : 3 + RL;
        exp_rd = (!bad && !we) ? ref_ram[addr[10:0]] : 32'd0;
        chk("one_ack", 32'(m0_ack) + 32'(m1_ack), 32'd1);
        chk("grant_who", 32'(m1_ack), 32'(m));
        chk("latency", 32'(cyc), 32'(exp_t));
        chk("err", 32'(m ? m1_err : m0_err), 32'(bad));
        chk("rdata", m ? m1_rdata : m0_rdata, exp_rd);
        chk("other_quiet", m ? (m0_rdata | 32'(m0_err)) : (m1_rdata | 32'(m1_err)), 32'd0);
        chk("we_pulses", 32'(we_cnt), 32'(!bad && we));
        chk("oe_cycles", 32'(oe_cnt), (!bad && !we) ? 32'(RL + 1) : 32'd0);
        if (!bad && we) begin
          chk("we_addr", we_addr, addr);
          chk("we_data", we_dat, wd);
          ref_ram[addr[10:0]] = wd;
        end
        ref_lg = m[0];
        if (m == 1) m1_req = 1'b0; else m0_req = 1'b0;
        we_cnt = 0; oe_cnt = 0;
        exp_t += 1;
        k++;
      end
    end
    if (k < order.size()) chk("ack_timeout", 32'(k), 32'(order.size()));
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
`ifdef ARB_LOCK_EN
    m0_lock = 0; m1_lock = 0;
`endif
    ref_lg = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_flags", {26'd0, m0_ack, m1_ack, m0_err, m1_err, mem_we, mem_oe}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata | mem_wdata, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    run_round(1, 0, 1, 0, 32'd5, 32'd0, 32'h0000002A, 32'd0);
    run_round(0, 1, 0, 0, 32'd0, 32'd5, 32'd0, 32'd0);
    run_round(1, 1, 0, 1, 32'd5, 32'd6, 32'd0, 32'h00001234);
    run_round(1, 1, 1, 0, 32'd6, 32'd5, 32'h00000055, 32'd0);
    run_round(1, 0, 0, 0, 32'hFFFF0000, 32'd0, 32'd0, 32'd0);
    run_round(0, 1, 1, 0, 32'd0, 32'd2047, 32'd0, 32'hCAFEF00D);
    run_round(1, 0, 0, 0, 32'd2047, 32'd0, 32'd0, 32'd0);
    run_round(0, 1, 1, 0, 32'd0, 32'd2048, 32'd0, 32'h11111111);

    // Reset in the RWAIT cycle of an m1 read.
    m1_req = 1; m1_we = 0; m1_addr = 32'd3;
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_oe", 32'(mem_oe), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_flags", {26'd0, m0_ack, m1_ack, m0_err, m1_err, mem_we, mem_oe}, 32'd0);
    chk("abort_addr", mem_address, 32'd0);
    m1_req = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (m0_ack || m1_ack) seen = 1;
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    reset = 1'b1;
    ref_lg = 1'b1;
    @(negedge clock);

`ifdef ARB_LOCK_EN
    begin
      int acks[$];
      int cyc;
      logic [31:0] first_rd;
      first_rd = '0;
      m0_req = 1; m0_we = 0; m0_addr = 32'd7; m0_lock = 1;
      m1_req = 1; m1_we = 1; m1_addr = 32'd9; m1_wdata = 32'hA5A5A5A5;
      cyc = 0;
      while (acks.size() < 3 && cyc < 80) begin
        @(negedge clock);
        cyc++;
        if (m0_ack) begin
          if (acks.size() == 0) first_rd = m0_rdata;
          acks.push_back(0);
          m0_req = 0;
          if (acks.size() == 1) begin
            @(negedge clock);
            cyc++;
            m0_req = 1; m0_we = 1; m0_addr = 32'd7; m0_wdata = 32'h00000777; m0_lock = 0;
          end
        end else if (m1_ack) begin
          acks.push_back(1);
          m1_req = 0;
        end
      end
      chk("lock_acks", 32'(acks.size()), 32'd3);
      if (acks.size() == 3) begin
        chk("lock_order0", 32'(acks[0]), 32'd0);
        chk("lock_order1", 32'(acks[1]), 32'd0);
        chk("lock_order2", 32'(acks[2]), 32'd1);
      end
      chk("lock_rd", first_rd, ref_ram[7]);
      ref_ram[7] = 32'h00000777;
      ref_ram[9] = 32'hA5A5A5A5;
      ref_lg = 1'b1;
      m0_req = 0; m1_req = 0;
      @(negedge clock);
      @(negedge clock);
    end
`else
    run_round(1, 1, 0, 0, 32'd5, 32'd6, 32'd0, 32'd0);
`endif

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1], 1'($urandom), 1'($urandom),
                rand_addr(), rand_addr(), $urandom, $urandom);
    end

    chk("we_oe_overlap", 32'(overlap_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intcode_mem_arbiter.md
Name: intcode_mem_arbiter

Overview:
Shares the single-port 32-bit word RAM between two bus masters: m0 (the intcode CPU) and m1 (program loader / debug master). Arbitrates round-robin and sequences each access as address-phase, optional read-wait and ack. Decodes out-of-range addresses into an error ack, so no master ever drives the RAM directly. Sits between the masters and the RAM; the memory-mapped I/O ports stay on the CPU side and are not routed through this block.

Parameters:
RAM_WORDS, 2048, number of RAM words; an address is valid iff addr < RAM_WORDS.
READ_LATENCY, 1, clock cycles from mem_oe asserted to mem_rdata valid (1..4).

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
m0_req, m1_req  in  1  access request; held high with stable addr/we/wdata until the matching ack.
m0_we, m1_we  in  1  1 = write, 0 = read.
m0_addr, m1_addr  in  32  word address.
m0_wdata, m1_wdata  in  32  write data.
m0_rdata, m1_rdata  out  32  read data; valid only in the ack cycle.
m0_ack, m1_ack  out  1  one-cycle completion pulse.
m0_err, m1_err  out  1  high together with ack when the address was out of range.
mem_address  out  32  RAM address.
mem_we  out  1  RAM write strobe.
mem_oe  out  1  RAM read enable.
mem_wdata  out  32  RAM write data.
mem_rdata  in  32  RAM registered read data.

Behaviour:
- Reset (async, reset low): state=IDLE, last_grant=m1 (so m0 wins the first tie), wait_cnt=0. All outputs are 0.
- States: IDLE, ACCESS, RWAIT, ACK.
- IDLE: if either req is high, grant one master, latch its addr/we/wdata, and go to ACCESS next cycle.
  - Only one requester: grant it.
  - Both requesting: grant the master that is not last_grant.
  - last_grant updates on grant.
- ACCESS, valid address:
  - Drive mem_address = latched addr.
  - Write: mem_we=1, mem_oe=0, mem_wdata = latched wdata for exactly one cycle, then go to ACK.
  - Read: mem_oe=1, mem_we=0; load wait_cnt=READ_LATENCY and go to RWAIT.
- ACCESS, invalid address (addr >= RAM_WORDS): mem_we and mem_oe stay 0, no RAM cycle occurs, set err and go straight to ACK.
- RWAIT:
  - mem_oe and mem_address are held and wait_cnt decrements each cycle.
  - When wait_cnt reaches 1, capture mem_rdata into the read buffer and go to ACK.
- ACK:
  - The granted master's ack is high for exactly one cycle; err is high in that cycle if the address was invalid.
  - rdata = buffer for a valid read, 0 for writes and errors.
  - The other master's ack, err and rdata stay 0.
  - Next state is IDLE.
- Latency from req sampled in IDLE to ack: write = 3 cycles; read = 3 + READ_LATENCY; error = 3.
- Back-to-back: at least one IDLE cycle separates two transactions. A master may drop req in the ack cycle; a req still high in IDLE counts as a new request.
- A req that drops before ack is a protocol violation; the arbiter completes the latched transaction anyway.
- mem_we and mem_oe are never high in the same cycle; mem_we is high for at most one cycle per transaction.
- Address compare is unsigned 32-bit; 0xFFFF0000 is invalid and produces an error ack.
- Reset asserted mid-transaction aborts it immediately: no ack, mem_we drops asynchronously, state=IDLE.

Optional Feature:
ARB_LOCK_EN:
- Defined:
  - Adds input ports m0_lock and m1_lock (1 bit each).
  - If the granted master's lock is high in its ACK cycle, the arbiter returns to IDLE with that master reserved.
  - The reserved master wins the next grant as soon as it requests, ignoring round-robin, so a read-modify-write stays atomic.
  - While reserved, the other master's requests wait.
  - Reservation ends at the first ack where lock is low.
- Undefined: the lock ports do not exist and arbitration is purely round-robin.

Test Plan:
- Reset, then m0 writes 0x0000002A to addr 5 -> mem_we high exactly 1 cycle with mem_address=5 and mem_wdata=0x2A; m0_ack 3 cycles after req; m0_err=0.
- m1 reads addr 5 with READ_LATENCY=1, RAM model returns 0x2A -> m1_ack 4 cycles after req, m1_rdata=0x0000002A, m0_ack stays 0.
- m0_req and m1_req raised in the same cycle, both kept high for 4 transactions -> grant order m0, m1, m0, m1.
- m0 reads addr 0xFFFF0000 -> no mem_oe or mem_we pulse; m0_ack and m0_err high together 3 cycles later; m0_rdata=0.
- reset pulled low in the RWAIT cycle of an m1 read -> all outputs 0 immediately, no m1_ack; after release, m0 wins the next tie.
- With ARB_LOCK_EN: m0 read at addr 7 with m0_lock=1 while m1_req is high, then m0 write to addr 7 with m0_lock=0 -> both m0 accesses complete before m1 is granted.
